// File: rtl/idecode32.sv
// ---------------------------------------------------------------------------
// idecode32 -- instruction decode / register-file stage of the single-cycle
// MIPS32 core.
//
// Splits the fetched instruction into rs/rt/rd indices and a 32-bit
// immediate, and holds the 32x32 GPR file. There are two combinational read
// ports plus a combinational debug port. Write-back selects between ALU
// result, load data, or the JAL return address.
//
// Parameters:
//   SP_INIT      reset value of $29 (stack pointer)
//
// Ports:
//   clock        in   system clock, GPR writes on rising edge
//   reset        in   asynchronous active-low reset
//   Instruction  in   [31:0] instruction from fetch
//   opcplus4     in   [31:0] JAL return value, written verbatim into $31
//   ALU_result   in   [31:0] execute-unit result
//   read_data    in   [31:0] data-memory load data
//   Jal          in   JAL write-back select (forces a write to $31)
//   RegWrite     in   write enable from control
//   RegDst       in   1 = destination rd, 0 = destination rt
//   MemtoReg     in   1 = write read_data, 0 = write ALU_result
//   read_data_1  out  [31:0] GPR[rs] (also the jr target for fetch)
//   read_data_2  out  [31:0] GPR[rt]
//   imme_extend  out  [31:0] zero/sign-extended Instruction[15:0]
//   dbg_addr     in   [4:0] debug read index
//   dbg_data     out  [31:0] GPR[dbg_addr]
// ---------------------------------------------------------------------------
module idecode32 #(
    parameter logic [31:0] SP_INIT = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Instruction,
    input  logic [31:0] opcplus4,
    input  logic [31:0] ALU_result,
    input  logic [31:0] read_data,
    input  logic        Jal,
    input  logic        RegWrite,
    input  logic        RegDst,
    input  logic        MemtoReg,
    output logic [31:0] read_data_1,
    output logic [31:0] read_data_2,
    output logic [31:0] imme_extend,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    // Only $1..$31 are stored; $0 is the constant zero.
    logic [31:0] r_regs [31:1];

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [15:0] w_imm;
    logic        w_zext;
    logic [4:0]  w_waddr;
    logic [31:0] w_wdata;
    logic        w_we;

    assign w_opcode = Instruction[31:26];
    assign w_rs     = Instruction[25:21];
    assign w_rt     = Instruction[20:16];
    assign w_rd     = Instruction[15:11];
    assign w_imm    = Instruction[15:0];

    // Logical immediates (andi/ori/xori) zero-extend; everything else,
    // sltiu included, sign-extends.
    assign w_zext      = (w_opcode == 6'h0C) || (w_opcode == 6'h0D) || (w_opcode == 6'h0E);
    assign imme_extend = w_zext ? {16'h0000, w_imm} : {{16{w_imm[15]}}, w_imm};

    // Jal dominates both selects and forces the write on its own.
    assign w_waddr = Jal ? 5'd31 : (RegDst ? w_rd : w_rt);
    assign w_wdata = Jal ? opcplus4 : (MemtoReg ? read_data : ALU_result);
    assign w_we    = RegWrite | Jal;

    // Reads are unbypassed: a same-cycle write becomes visible after the edge.
    assign read_data_1 = (w_rs     == 5'd0) ? 32'h0 : r_regs[w_rs];
    assign read_data_2 = (w_rt     == 5'd0) ? 32'h0 : r_regs[w_rt];
    assign dbg_data    = (dbg_addr == 5'd0) ? 32'h0 : r_regs[dbg_addr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= (i == 29) ? SP_INIT : 32'h0;
            end
        end else if (w_we && (w_waddr != 5'd0)) begin
            r_regs[w_waddr] <= w_wdata;
        end
    end

endmodule
